gbc_clock_enable_bank: RTL
==========================

# gbc_clock_enable_bank

Parametrised clock-enable generator for the GBC core. It replaces free-running derived clocks with single-cycle enable pulses on one fabric clock. Each of NUM_CH channels has a runtime-programmable divide ratio, glitch-free ratio updates and a square-wave phase output. A CGB double-speed switch, requested and acknowledged by handshake, halves the period of selected channels at a safe boundary. CPU, DMA, timer and memory-side logic consume the enables instead of separate clock nets.

## Interface
Parameters:
- NUM_CH, 4, number of enable channels.
- DIV_W, 8, width of each channel's divide field.
- SPEED_MASK, 4'b0011, channels whose period is halved in double-speed mode (bit i = channel i).

Ports (one clock; reset is synchronous and active-high):
- I_CLK  in  1  fabric clock; all state updates on its rising edge.
- I_SYNC_RESET  in  1  synchronous active-high reset.
- I_DIV  in  NUM_CH*DIV_W  packed divide fields; channel i uses bits [i*DIV_W +: DIV_W]; period = D+1 cycles.
- I_CH_EN  in  NUM_CH  per-channel run enable.
- I_SPEED_REQ  in  1  one-cycle pulse requesting a toggle of speed mode.
- O_SPEED_ACK  out  1  one-cycle pulse when the toggle takes effect.
- O_DOUBLE_SPEED  out  1  current mode (1 = double speed).
- O_CE  out  NUM_CH  registered one-cycle enable pulses.
- O_PHASE  out  NUM_CH  registered square wave, toggles on every O_CE of its channel.

## Operation
- Per channel: counter cnt[DIV_W-1:0], shadow divide S, terminal T.
- T = S in normal mode or for unmasked channels. For masked channels in double speed, T = ((S+1)>>1) - 1, clamped to 0 when S = 0. Computation is DIV_W+1 bits wide, so S = all-ones does not overflow.
- Enabled channel, cnt < T: cnt increments, O_CE = 0.
- Enabled channel, cnt == T: cnt <= 0, O_CE = 1 next cycle, O_PHASE toggles, and S reloads from I_DIV. This is the only point where S changes, so a period is never truncated or stretched mid-count.
- Disabled channel: cnt held 0, O_CE 0, O_PHASE forced 0, and S tracks I_DIV every cycle.
- Speed switch:
  - I_SPEED_REQ sets internal pending.
  - A request while pending is already set is ignored; it does not toggle twice.
  - Pending is applied on the cycle channel 0 reaches cnt == T, or on the next cycle if channel 0 is disabled.
  - On apply: O_DOUBLE_SPEED toggles, O_SPEED_ACK pulses, pending clears, and cnt of every masked channel is forced to 0 in the same cycle so all masked channels restart phase-aligned. Unmasked channels are unaffected.
- Simultaneous I_SPEED_REQ and an apply edge:
  - If pending was clear, the request is latched and applied at the next channel 0 boundary.
  - If pending was set, the apply occurs and the new request is dropped.

## Timing
- Reset values: all cnt 0, O_CE 0, O_PHASE 0, O_DOUBLE_SPEED 0, O_SPEED_ACK 0, pending 0. S loads from I_DIV during reset.
- After reset deasserts, an enabled channel with divide D first asserts O_CE after the (D+1)th rising edge, then every D+1 cycles.
- D = 0 gives O_CE high every cycle; O_PHASE then toggles every cycle.
- Enable rising: the first O_CE arrives T+1 cycles later. Enable falling: O_CE is 0 from the next cycle.
- Reset mid-count or mid-switch: everything returns to reset values next cycle, and a pending request is lost.
- O_SPEED_ACK is coincident with the O_DOUBLE_SPEED edge, and at most one pulse occurs per request.

## Structure
- Package gbc_clk_pkg holds:
  - the DIV_W default;
  - a function computing T from (S, double, masked);
  - the reset constants.
- Sub-module gbc_ce_channel holds one counter, shadow, CE and phase register. It is instantiated NUM_CH times via generate, with inputs double-speed, masked and force_zero.
- The top level owns the pending/apply FSM (states NORMAL, NORMAL_PEND, DOUBLE, DOUBLE_PEND).

## Test plan
- Reset, ch0 D=3 enabled: O_CE[0] high on cycles 4, 8, 12; O_PHASE[0] reads 1, 0, 1 after each pulse.
- D=0 on ch1: O_CE[1] high on every cycle.
- Ch2 running at D=7; change I_DIV to 2 at count 3: the current period completes at 8 cycles, then the period is 3.
- Mask 0011, ch0 D=7, ch1 D=3, pulse I_SPEED_REQ:
  - ACK arrives at ch0's next boundary;
  - then ch0 period is 4 and ch1 period is 2, with both cnt zeroed together;
  - ch2 period is unchanged.
- Second I_SPEED_REQ while pending: exactly one ACK and one toggle.
- Disable ch3 mid-count, re-enable: O_CE[3] and O_PHASE[3] are 0 while disabled, and the first pulse comes T+1 cycles after re-enable. Assert I_SYNC_RESET during pending: O_DOUBLE_SPEED stays 0 and no ACK occurs.

Source files
------------

// File: rtl/gbc_clk_pkg.sv
// gbc_clk_pkg
// Shared definitions for the GBC clock-enable bank:
//   - default channel count, divide-field width and double-speed mask
//   - speed-mode FSM state encoding (exposed for debug/checkers)
//   - reset constants for every register in the bank
//   - term_calc(): the terminal count for a channel given its shadow divide,
//     the current speed mode and whether the channel is double-speed masked
package gbc_clk_pkg;

    localparam int          NUM_CH_DEF     = 4;
    localparam int          DIV_W_DEF      = 8;
    localparam logic [3:0]  SPEED_MASK_DEF = 4'b0011;

    typedef enum logic [1:0] {
        ST_NORMAL      = 2'd0,
        ST_NORMAL_PEND = 2'd1,
        ST_DOUBLE      = 2'd2,
        ST_DOUBLE_PEND = 2'd3
    } speed_state_e;

    localparam speed_state_e RST_STATE = ST_NORMAL;
    localparam logic         RST_ACK   = 1'b0;
    localparam logic         RST_CE    = 1'b0;
    localparam logic         RST_PHASE = 1'b0;

    // Terminal count. Normal mode (or unmasked channel): T = S, period S+1.
    // Double speed on a masked channel: T = ((S+1)>>1) - 1, so the period is
    // halved (rounded up). The +1 is done one bit wider than S so an all-ones
    // divide does not wrap. S = 0 stays at 0 (already one cycle per period).
    // Operates on 32-bit values; callers zero-extend and truncate back.
    function automatic logic [31:0] term_calc(input logic [31:0] s,
                                              input logic        dbl,
                                              input logic        masked);
        logic [31:0] t;
        if (!(dbl && masked)) begin
            t = s;
        end else if (s == 32'd0) begin
            t = 32'd0;
        end else begin
            t = 32'(({1'b0, s} + 33'd1) >> 1) - 32'd1;
        end
        return t;
    endfunction

endpackage

// File: rtl/gbc_clock_enable_bank_if.sv
// gbc_clock_enable_bank_if
// Bundle of the control/status signals of the clock-enable bank.
//   I_DIV          packed divide fields, channel i at [i*DIV_W +: DIV_W]
//   I_CH_EN        per-channel run enable
//   I_SPEED_REQ    speed-toggle request pulse
//   O_SPEED_ACK    speed-toggle completion pulse
//   O_DOUBLE_SPEED current speed mode (1 = double)
//   O_CE           registered one-cycle enable pulses
//   O_PHASE        registered square wave per channel
//   dbg_state      speed FSM state (observability only)
//   dbg_term       per-channel "at terminal count this cycle" (observability only)
//
// Speed handshake: I_SPEED_REQ is a single-cycle request with no ready/back-
// pressure; a request arriving while one is already pending is absorbed.
// O_SPEED_ACK is a single-cycle completion pulse, registered and coincident
// with the O_DOUBLE_SPEED edge, at most one per accepted request.
interface gbc_clock_enable_bank_if
    import gbc_clk_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DIV_W  = DIV_W_DEF
);
    logic [NUM_CH*DIV_W-1:0] I_DIV;
    logic [NUM_CH-1:0]       I_CH_EN;
    logic                    I_SPEED_REQ;
    logic                    O_SPEED_ACK;
    logic                    O_DOUBLE_SPEED;
    logic [NUM_CH-1:0]       O_CE;
    logic [NUM_CH-1:0]       O_PHASE;
    speed_state_e            dbg_state;
    logic [NUM_CH-1:0]       dbg_term;

    // Driver side (CPU/config logic or testbench).
    modport master (
        output I_DIV, I_CH_EN, I_SPEED_REQ,
        input  O_SPEED_ACK, O_DOUBLE_SPEED, O_CE, O_PHASE, dbg_state, dbg_term
    );

    // Clock-enable bank side.
    modport slave (
        input  I_DIV, I_CH_EN, I_SPEED_REQ,
        output O_SPEED_ACK, O_DOUBLE_SPEED, O_CE, O_PHASE, dbg_state, dbg_term
    );
endinterface

// File: rtl/gbc_ce_channel.sv
// gbc_ce_channel
// One clock-enable channel: counter, shadow divide, CE and phase registers.
//   clk_i, rst_i   fabric clock, synchronous active-high reset
//   en_i           run enable
//   div_i          live divide value from the register file
//   double_i       current speed mode
//   masked_i       channel participates in double-speed halving
//   force_zero_i   restart the counter (speed-mode switch alignment)
//   term_o         counter is at its terminal value this cycle (enabled only)
//   ce_o           registered one-cycle enable pulse
//   phase_o        registered square wave, toggles with every ce_o
// DIV_W is limited to 32 by the shared terminal-count helper.
module gbc_ce_channel
    import gbc_clk_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             double_i,
    input  logic             masked_i,
    input  logic             force_zero_i,
    output logic             term_o,
    output logic             ce_o,
    output logic             phase_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             ce_q, ce_d;
    logic             phase_q, phase_d;
    logic [DIV_W-1:0] term;
    logic             hit;

    assign term = DIV_W'(term_calc(32'(shadow_q), double_i, masked_i));

    // >= rather than == so that a counter can never run past its terminal;
    // in reachable states the two are identical.
    assign hit    = (cnt_q >= term);
    assign term_o = en_i && hit;

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        ce_d     = 1'b0;
        phase_d  = phase_q;
        if (!en_i) begin
            // Idle: hold at zero and keep the shadow live so the first
            // period after enabling uses the current divide.
            cnt_d    = '0;
            phase_d  = 1'b0;
            shadow_d = div_i;
        end else if (hit) begin
            // Period boundary: the only place the shadow divide may change.
            cnt_d    = '0;
            ce_d     = 1'b1;
            phase_d  = ~phase_q;
            shadow_d = div_i;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        if (force_zero_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            shadow_q <= div_i;
            ce_q     <= RST_CE;
            phase_q  <= RST_PHASE;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ce_q     <= ce_d;
            phase_q  <= phase_d;
        end
    end

    assign ce_o    = ce_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/gbc_clock_enable_bank.sv
// gbc_clock_enable_bank
// Generates NUM_CH single-cycle clock-enable pulses from one fabric clock,
// each with a runtime divide ratio (period = D+1), plus a CGB double-speed
// mode that halves the period of the SPEED_MASK channels.
//   I_CLK          fabric clock
//   I_SYNC_RESET   synchronous active-high reset
//   ce_bus         control/status bundle (slave side), see the interface file
// The speed FSM holds a request pending until channel 0's next period
// boundary (or the next cycle if channel 0 is idle), then flips the mode,
// pulses the ack and restarts every masked channel in phase.
module gbc_clock_enable_bank
    import gbc_clk_pkg::*;
#(
    parameter int                NUM_CH     = NUM_CH_DEF,
    parameter int                DIV_W      = DIV_W_DEF,
    parameter logic [NUM_CH-1:0] SPEED_MASK = NUM_CH'(SPEED_MASK_DEF)
) (
    input  logic                    I_CLK,
    input  logic                    I_SYNC_RESET,
    gbc_clock_enable_bank_if.slave  ce_bus
);

    speed_state_e      state_q, state_d;
    logic              ack_q;
    logic              apply;
    logic              apply_edge;
    logic              double_speed;
    logic [NUM_CH-1:0] term_vec;
    logic [NUM_CH-1:0] ce_vec;
    logic [NUM_CH-1:0] phase_vec;

    assign double_speed = (state_q == ST_DOUBLE) || (state_q == ST_DOUBLE_PEND);

    // Safe switch point: channel 0 wrapping, or channel 0 idle.
    assign apply_edge = term_vec[0] || !ce_bus.I_CH_EN[0];

    // Next-state logic. A request is only looked at in the non-pending
    // states, so a request while pending (including one coinciding with the
    // apply cycle) is dropped, and a request arriving on a boundary while
    // idle waits for the following boundary.
    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (ce_bus.I_SPEED_REQ) state_d = ST_NORMAL_PEND;
            end
            ST_NORMAL_PEND: begin
                if (apply_edge) begin
                    apply   = 1'b1;
                    state_d = ST_DOUBLE;
                end
            end
            ST_DOUBLE: begin
                if (ce_bus.I_SPEED_REQ) state_d = ST_DOUBLE_PEND;
            end
            ST_DOUBLE_PEND: begin
                if (apply_edge) begin
                    apply   = 1'b1;
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RESET) begin
            state_q <= RST_STATE;
            ack_q   <= RST_ACK;
        end else begin
            state_q <= state_d;
            ack_q   <= apply;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        gbc_ce_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk_i        (I_CLK),
            .rst_i        (I_SYNC_RESET),
            .en_i         (ce_bus.I_CH_EN[i]),
            .div_i        (ce_bus.I_DIV[i*DIV_W +: DIV_W]),
            .double_i     (double_speed),
            .masked_i     (SPEED_MASK[i]),
            .force_zero_i (apply && SPEED_MASK[i]),
            .term_o       (term_vec[i]),
            .ce_o         (ce_vec[i]),
            .phase_o      (phase_vec[i])
        );
    end

    assign ce_bus.O_CE           = ce_vec;
    assign ce_bus.O_PHASE        = phase_vec;
    assign ce_bus.O_SPEED_ACK    = ack_q;
    assign ce_bus.O_DOUBLE_SPEED = double_speed;
    assign ce_bus.dbg_state      = state_q;
    assign ce_bus.dbg_term       = term_vec;

endmodule
